mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6: word-address width of the shared 64x16 program/data memory.
REQ-002 Parameter DATA_W, default 16: memory word width.
REQ-003 Parameter STARVE_LIM, default 8: consecutive cycles the debug port may lose arbitration before it is forced ahead of the CPU.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; ports clock and reset_n.
REQ-005 clock  in  1  rising-edge system clock (CLOCK_50 domain).
REQ-006 reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-007 cpu_req / cpu_we  in  1 / 1  CPU access request and write qualifier; held until cpu_gnt.
REQ-008 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU word address and write data (IouD-muxed PC or ALU address).
REQ-009 cpu_gnt / cpu_rvalid  out  1 / 1  one-cycle grant pulse / one-cycle read-data-valid pulse.
REQ-010 cpu_rdata  out  DATA_W  registered read data (IR/MDR source), held until the next CPU read completes.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same widths and meaning as the cpu_* ports, for the switch/LCD inspection port.
REQ-012 dbg_err  out  1  one-cycle pulse on a rejected debug write.
REQ-013 mem_addr / mem_wdata  out  ADDR_W / DATA_W; mem_re / mem_we  out  1 / 1: registered memory command.
REQ-014 mem_rdata  in  DATA_W: memory read data, valid exactly one cycle after mem_re.

Function
REQ-015 FSM states: IDLE, ACC, RESP. IDLE->ACC when any request is pending; ACC->RESP unconditionally; RESP->ACC if a request is pending, else RESP->IDLE.
REQ-016 Arbitration is performed on entry to ACC: the CPU wins, except that the debug port wins when starve_cnt >= STARVE_LIM.
REQ-017 In ACC: mem_* are driven from the winner's inputs, exactly one of mem_re/mem_we is high, and the winner's gnt is high for that single cycle.
REQ-018 In RESP: for a read, mem_rdata is captured into the winner's rdata on the RESP->next edge, and the winner's rvalid is high in the following cycle. No rvalid is generated for writes.
REQ-019 Latency: request seen in IDLE at edge k gives gnt in cycle k+1 and rvalid in cycle k+3. Sustained throughput is one access per 2 cycles.
REQ-020 starve_cnt is saturating at STARVE_LIM.
  - Increments on each ACC cycle in which dbg_req=1 and the CPU is granted.
  - Clears on a debug grant or when dbg_req=0.
REQ-021 Outside ACC, mem_re=mem_we=0. mem_addr and mem_wdata hold their last values.
REQ-022 A requester that drops req before gnt is not serviced. Simultaneous requests in IDLE follow REQ-016.
REQ-023 A request whose address is >= 2**ADDR_W cannot occur, by width. Addresses wrap modulo 64.

Reset
REQ-024 Reset SHALL force state=IDLE, starve_cnt=0, and all gnt/rvalid/mem_re/mem_we/dbg_err=0.
REQ-025 Reset SHALL clear cpu_rdata, dbg_rdata, mem_addr and mem_wdata to 0.
REQ-026 An access in flight when reset asserts SHALL be abandoned: no gnt, rvalid or write is issued after reset.

Configuration
REQ-027 Macro MEM_ARBITER_DBG_WRITE_EN. When defined, debug writes behave as in REQ-017.
REQ-028 When MEM_ARBITER_DBG_WRITE_EN is undefined, a granted debug write:
  - drives mem_we=0 and mem_re=0;
  - still pulses dbg_gnt;
  - pulses dbg_err in the same cycle.
  Without the macro, dbg_err is tied 0 otherwise.

Structure
REQ-029 Package mips16_pkg SHALL hold ADDR_W and DATA_W defaults, the arb_state_t enum (IDLE/ACC/RESP) and the requester-id type.
REQ-030 One sub-module, arb_starve_ctr, SHALL implement the saturating starvation counter. All other logic stays flat.

Verification
REQ-031 Single CPU read of addr 6'h05 with memory word 16'h8123: cpu_gnt at cycle 1, mem_re=1 with mem_addr=5 at cycle 1, cpu_rvalid=1 with cpu_rdata=16'h8123 at cycle 3.
REQ-032 cpu_req and dbg_req asserted together at cycle 0: CPU granted first; debug granted in the next ACC, with dbg_gnt at cycle 3.
REQ-033 cpu_req held continuously with dbg_req=1 and STARVE_LIM=8: debug is granted on the 9th ACC, and starve_cnt returns to 0.
REQ-034 Debug write 16'hBEEF to addr 6'h3F:
  - with the macro: mem_we=1, mem_addr=63, dbg_err=0;
  - without the macro: mem_we=0, dbg_gnt=1, dbg_err=1.
REQ-035 reset_n=0 during ACC of a CPU read: the next cycle is IDLE with all outputs 0, and no cpu_rvalid follows.
REQ-036 CPU read of addr 6'h3F followed back-to-back by a read of 6'h00: grants 2 cycles apart, with no idle gap.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared types and defaults for the mips16 memory arbiter.
// Holds bus width defaults, arbiter FSM states and requester ids.
package mips16_pkg;

  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_LIM = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_DBG
  } req_id_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of ACC cycles the debug port lost to the CPU.
// Ports: clock, reset_n (sync, active-low), inc, clr in; cnt out.
module arb_starve_ctr #(
  parameter int LIM = 8,
  parameter int CW  = $clog2(LIM + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] MAX = CW'(LIM);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter for a shared single-port memory.
// Ports: clock, reset_n; cpu_* and dbg_* request/grant/read ports;
//   dbg_err; registered mem_* command; mem_rdata (1-cycle latency).
// Macro MEM_ARBITER_DBG_WRITE_EN: when undefined, debug writes are
//   granted but rejected (no memory write, dbg_err pulse).
module mem_arbiter
  import mips16_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] SLIM = CW'(STARVE_LIM);

  arb_state_t state, state_nx;
  req_id_t    win;
  logic       rd;

  logic          any_req;
  logic          starved;
  logic          dbg_wins;
  logic          sel_we;
  logic          load;
  logic          capture;
  logic          re_nx;
  logic          we_nx;
  logic          err_nx;
  logic          st_inc;
  logic          st_clr;
  logic [CW-1:0] starve_cnt;

  assign any_req  = cpu_req | dbg_req;
  assign starved  = starve_cnt >= SLIM;
  assign dbg_wins = dbg_req & (~cpu_req | starved);
  assign sel_we   = dbg_wins ? dbg_we : cpu_we;
  assign capture  = (state == RESP) & rd;

  // The counter is only meaningful while debug keeps asking.
  assign st_inc = (state == ACC) & (win == REQ_CPU) & dbg_req;
  assign st_clr = ~dbg_req | ((state == ACC) & (win == REQ_DBG));

  arb_starve_ctr #(
    .LIM (STARVE_LIM),
    .CW  (CW)
  ) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (st_inc),
    .clr     (st_clr),
    .cnt     (starve_cnt)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // load marks the edge that enters ACC; arbitration happens there.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    re_nx    = 1'b0;
    we_nx    = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = ACC;
          load     = 1'b1;
        end
      end
      ACC: state_nx = RESP;
      RESP: begin
        if (any_req) begin
          state_nx = ACC;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) begin
      re_nx = ~sel_we;
      we_nx = sel_we;
`ifndef MEM_ARBITER_DBG_WRITE_EN
      if (dbg_wins && dbg_we) begin
        we_nx  = 1'b0;
        err_nx = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      win        <= REQ_CPU;
      rd         <= 1'b0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      dbg_err    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_gnt    <= load & ~dbg_wins;
      dbg_gnt    <= load & dbg_wins;
      mem_re     <= re_nx;
      mem_we     <= we_nx;
      dbg_err    <= err_nx;
      cpu_rvalid <= capture & (win == REQ_CPU);
      dbg_rvalid <= capture & (win == REQ_DBG);
      if (load) begin
        win       <= dbg_wins ? REQ_DBG : REQ_CPU;
        rd        <= ~sel_we;
        mem_addr  <= dbg_wins ? dbg_addr : cpu_addr;
        mem_wdata <= dbg_wins ? dbg_wdata : cpu_wdata;
      end
      if (capture && win == REQ_CPU) cpu_rdata <= mem_rdata;
      if (capture && win == REQ_DBG) dbg_rdata <= mem_rdata;
    end
  end

endmodule
